stream_rx_demux: RTL and testbench
==================================

Name: stream_rx_demux

Overview:
Parametrised AXI-Stream receive front end for the accelerator's load path. It accepts a DMA MM2S stream and latches the data type once per packet. Each beat is steered onto one of NUM_CH one-hot valid lanes (feature / weight / bias / leakyrelu / ...). A 2-entry skid buffer gives full throughput with downstream backpressure, and the block reports packet completion, beat count and length errors to the main controller.

Parameters:
DATA_W, 64, stream and output data width (multiple of 8)
KEEP_W, DATA_W/8, tkeep width
NUM_CH, 4, number of destination channels
TYPE_W, 2, width of data_type
CNT_W, 16, width of beat counter and exp_beats

Ports:
sclk  in  1  clock
s_rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_W  stream data
s_axis_tkeep  in  KEEP_W  byte enables, passed through
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tlast  in  1  last beat of packet
rx_en  in  1  controller permits reception
data_type  in  TYPE_W  destination channel, sampled at packet start
exp_beats  in  CNT_W  expected packet length in beats; 0 = no check
rx_data  out  DATA_W  output data
rx_keep  out  KEEP_W  output byte enables
rx_vld  out  NUM_CH  one-hot channel valid
rx_last  out  1  marks last beat on output
rx_rdy  in  1  downstream ready, common to all channels
write_finish  out  1  one-cycle completion pulse
len_err  out  1  length mismatch, valid with write_finish
beat_cnt  out  CNT_W  beats accepted in current/last packet
keep_err  out  1  see Optional Feature

Behaviour:
- Reset: s_rst_n asynchronous, active-low, clock sclk. On reset, all outputs are 0, FSM is in IDLE and the skid buffer is empty. A reset mid-packet discards all buffered beats.
- FSM states: IDLE, RECV, DONE.
- IDLE -> RECV when rx_en=1. On that edge: latch data_type into cur_type, clear beat_cnt, clear last_seen.
- RECV -> DONE on the output handshake of the last beat (any rx_vld bit high or drop-mode beat, rx_last=1, rx_rdy=1).
- DONE -> IDLE unconditionally after 1 cycle. write_finish=1 only during DONE.
- s_axis_tready = (state==RECV) & rx_en & !skid_full & !last_seen. It is low in IDLE and DONE.
- When rx_en drops mid-packet, tready goes low and the FSM stays in RECV. Reception resumes when rx_en returns; no beats are lost.
- Buffering: output register plus one skid register.
  - An accepted beat reaches the output on the next cycle when the output is empty or being drained.
  - Otherwise the beat goes to the skid register, and tready drops the following cycle.
  - Sustained throughput is 1 beat/cycle while rx_rdy=1.
- Output hold: while rx_rdy=0, rx_data, rx_keep, rx_vld and rx_last are held stable.
- Output idle value: when no beat is held, rx_vld=0 and rx_data=0.
- Channel select: rx_vld[cur_type]=1 for a held beat.
  - If cur_type >= NUM_CH, beats are accepted and drained internally, with rx_vld=0 and no rx_rdy needed.
  - write_finish still pulses in that case.
- Beat counting: beat_cnt increments on every s_axis handshake and saturates at 2^CNT_W-1. It holds its value after DONE until the next IDLE->RECV.
- last_seen is set on acceptance of a tlast beat and blocks further acceptance until the next packet.
- len_err = write_finish & (exp_beats!=0) & (beat_cnt!=exp_beats). exp_beats is sampled during DONE.
- Packet boundaries: data_type changes during RECV are ignored. A new packet always requires passing through IDLE.

Optional Feature:
STREAM_RX_KEEP_CHECK_EN.
- Defined: keep_err is set when a non-last beat is accepted with s_axis_tkeep != all-ones. It is sticky until the next IDLE->RECV.
- Undefined: keep_err is tied to 0 and no check logic is built.

Test Plan:
1. rx_en=1, data_type=1, exp_beats=4, 4 beats 0x11..0x44 back-to-back, rx_rdy=1 -> each beat appears on rx_vld=4'b0010 one cycle after acceptance; write_finish pulses once; len_err=0; beat_cnt=4.
2. Same 4-beat packet with rx_rdy=0 for cycles 2-5 -> tready drops after 2 buffered beats; output held stable; all 4 beats delivered in order with no loss or duplication.
3. data_type=3, exp_beats=3, packet of 5 beats -> rx_vld=4'b1000 on all 5 beats; write_finish with len_err=1; beat_cnt=5.
4. rx_en deasserted for 3 cycles after beat 2 of 6 -> tready=0 during the gap; 6 beats received; single write_finish.
5. Assert s_rst_n=0 after beat 2 with the skid buffer full -> all outputs 0 immediately; next packet after reset is received cleanly.
6. With STREAM_RX_KEEP_CHECK_EN defined, beat 1 has tkeep=0x0F -> keep_err=1 until next packet start. Without the macro -> keep_err stays 0.

Source files
------------

// File: rtl/stream_rx_demux.sv
// AXI-Stream receive front end: per-packet type latch, one-hot channel steering, 2-entry skid buffer.
// Optional macro STREAM_RX_KEEP_CHECK_EN builds the sticky partial-tkeep detector behind keep_err.
module stream_rx_demux #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W/8,
  parameter int NUM_CH = 4,
  parameter int TYPE_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              rx_en,
  input  logic [TYPE_W-1:0] data_type,
  input  logic [CNT_W-1:0]  exp_beats,
  output logic [DATA_W-1:0] rx_data,
  output logic [KEEP_W-1:0] rx_keep,
  output logic [NUM_CH-1:0] rx_vld,
  output logic              rx_last,
  input  logic              rx_rdy,
  output logic              write_finish,
  output logic              len_err,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              keep_err
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  state_t            state;
  logic [TYPE_W-1:0] cur_type;
  logic [31:0]       type_ext;
  logic              last_seen;
  beat_t             in_b, out_q, sk_q;
  logic              out_vld, sk_vld;
  logic              acc, drop, drain, out_free, pkt_start;

  assign in_b      = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
  assign type_ext  = 32'(cur_type);
  // Out-of-range types have no lane: beats drain internally without rx_rdy.
  assign drop      = (type_ext >= NUM_CH);
  assign drain     = out_vld & (rx_rdy | drop);
  assign out_free  = ~out_vld | drain;
  assign pkt_start = (state == IDLE) & rx_en;

  assign s_axis_tready = (state == RECV) & rx_en & ~sk_vld & ~last_seen;
  assign acc           = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= IDLE;
      cur_type  <= '0;
      beat_cnt  <= '0;
      last_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rx_en) begin
          state     <= RECV;
          cur_type  <= data_type;
          beat_cnt  <= '0;
          last_seen <= 1'b0;
        end
        RECV: begin
          if (acc) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
            if (s_axis_tlast)   last_seen <= 1'b1;
          end
          if (drain & out_q.last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register refills from skid first to keep order; skid only catches a beat while output stalls.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      out_q   <= '0;
      out_vld <= 1'b0;
      sk_q    <= '0;
      sk_vld  <= 1'b0;
    end else if (out_free) begin
      if (sk_vld) begin
        out_q   <= sk_q;
        out_vld <= 1'b1;
        sk_vld  <= 1'b0;
      end else if (acc) begin
        out_q   <= in_b;
        out_vld <= 1'b1;
      end else begin
        out_q   <= '0;
        out_vld <= 1'b0;
      end
    end else if (acc) begin
      sk_q   <= in_b;
      sk_vld <= 1'b1;
    end
  end

  assign rx_data = out_q.data;
  assign rx_keep = out_q.keep;
  assign rx_last = out_q.last;

  always_comb begin
    rx_vld = '0;
    for (int i = 0; i < NUM_CH; i++)
      rx_vld[i] = out_vld & ~drop & (type_ext == 32'(i));
  end

  assign write_finish = (state == DONE);
  assign len_err      = write_finish & (exp_beats != '0) & (beat_cnt != exp_beats);

`ifdef STREAM_RX_KEEP_CHECK_EN
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)                                          keep_err <= 1'b0;
    else if (pkt_start)                                    keep_err <= 1'b0;
    else if (acc & ~s_axis_tlast & (s_axis_tkeep != '1))   keep_err <= 1'b1;
  end
`else
  assign keep_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_rx_demux.sv
// Scoreboard bench for stream_rx_demux: beats queued on input handshake, popped on output handshake.
module tb_stream_rx_demux;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic        rx_en;
  logic [1:0]  data_type;
  logic [15:0] exp_beats;
  logic [63:0] rx_data;
  logic [7:0]  rx_keep;
  logic [3:0]  rx_vld;
  logic        rx_last, rx_rdy, write_finish, len_err, keep_err;
  logic [15:0] beat_cnt;

`ifdef STREAM_RX_KEEP_CHECK_EN
  localparam logic KE_EXP = 1'b1;
`else
  localparam logic KE_EXP = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  ch;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   lat_chk = 0;

  stream_rx_demux dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .rx_en(rx_en), .data_type(data_type), .exp_beats(exp_beats),
    .rx_data(rx_data), .rx_keep(rx_keep), .rx_vld(rx_vld), .rx_last(rx_last), .rx_rdy(rx_rdy),
    .write_finish(write_finish), .len_err(len_err), .beat_cnt(beat_cnt), .keep_err(keep_err)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output side: pop on handshake, and verify outputs hold while stalled.
  logic        prev_stall = 0;
  logic [63:0] prev_data;
  logic [3:0]  prev_vld;
  always @(negedge sclk) begin
    exp_t e;
    if (s_rst_n && rx_vld != 0 && rx_rdy) begin
      if (sb.size() == 0) check("sb_unexpected", {60'd0, rx_vld}, 64'd0);
      else begin
        e = sb.pop_front();
        check("rx_data", rx_data, e.data);
        check("rx_keep", {56'd0, rx_keep}, {56'd0, e.keep});
        check("rx_last", {63'd0, rx_last}, {63'd0, e.last});
        check("rx_vld",  {60'd0, rx_vld}, {60'd0, e.ch});
        if (lat_chk) check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
    if (s_rst_n && prev_stall) begin
      check("hold_data", rx_data, prev_data);
      check("hold_vld", {60'd0, rx_vld}, {60'd0, prev_vld});
    end
    prev_stall = s_rst_n && rx_vld != 0 && !rx_rdy;
    prev_data  = rx_data;
    prev_vld   = rx_vld;
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [3:0] ch);
    exp_t e;
    bit   ok = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sclk);
      if (s_axis_tready) begin
        @(posedge sclk); #1;
        e.data = d; e.keep = k; e.last = l; e.ch = ch; e.cyc = cyc;
        sb.push_back(e);
        ok = 1;
        break;
      end
    end
    if (!ok) check("tready_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_pkt(input int typ, input int exp, input int n, input logic [63:0] base,
                         input int gap_after, input int bad_keep);
    data_type = 2'(typ); exp_beats = 16'(exp); rx_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_beat(base * 64'(i + 1), (i == bad_keep) ? 8'h0F : 8'hFF, i == n - 1, 4'(1 << typ));
      if (i == gap_after) begin
        rx_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge sclk);
          check("gap_tready", {63'd0, s_axis_tready}, 64'd0);
        end
        @(posedge sclk); #1 rx_en = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_done(input logic exp_len_err, input int exp_cnt);
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sclk);
      if (write_finish) begin found = 1; break; end
    end
    if (!found) check("write_finish_timeout", 64'd0, 64'd1);
    else begin
      check("len_err", {63'd0, len_err}, {63'd0, exp_len_err});
      check("beat_cnt", {48'd0, beat_cnt}, 64'(exp_cnt));
      check("sb_drained", 64'(sb.size()), 64'd0);
      @(negedge sclk);
      check("wf_single_pulse", {63'd0, write_finish}, 64'd0);
    end
    rx_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    s_rst_n = 0; s_axis_tdata = 0; s_axis_tkeep = 0; s_axis_tvalid = 0; s_axis_tlast = 0;
    rx_en = 0; data_type = 0; exp_beats = 0; rx_rdy = 1;
    repeat (3) @(posedge sclk);
    #1;
    check("rst_tready", {63'd0, s_axis_tready}, 64'd0);
    check("rst_rx_vld", {60'd0, rx_vld}, 64'd0);
    check("rst_rx_data", rx_data, 64'd0);
    check("rst_wf", {63'd0, write_finish}, 64'd0);
    check("rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
    check("rst_keep_err", {63'd0, keep_err}, 64'd0);
    s_rst_n = 1;
    repeat (2) @(posedge sclk);
    #1;

    // 1: back-to-back, one-cycle latency
    lat_chk = 1;
    run_pkt(1, 4, 4, 64'h11, -1, -1);
    wait_done(1'b0, 4);
    lat_chk = 0;

    // 2: downstream stall, skid fills and tready drops
    @(posedge sclk); #1 rx_rdy = 0;
    fork
      run_pkt(1, 4, 4, 64'h100, -1, -1);
      begin
        repeat (6) @(negedge sclk);
        check("stall_tready", {63'd0, s_axis_tready}, 64'd0);
        check("stall_cnt", {48'd0, beat_cnt}, 64'd2);
        @(posedge sclk); #1 rx_rdy = 1;
      end
    join
    wait_done(1'b0, 4);

    // 3: length mismatch on channel 3
    run_pkt(3, 3, 5, 64'h2000, -1, -1);
    wait_done(1'b1, 5);

    // 4: rx_en gap mid-packet
    run_pkt(2, 6, 6, 64'h30000, 1, -1);
    wait_done(1'b0, 6);

    // 6: partial tkeep on a non-last beat
    run_pkt(0, 3, 3, 64'h400000, -1, 1);
    wait_done(1'b0, 3);
    repeat (3) @(negedge sclk);
    check("keep_err_sticky", {63'd0, keep_err}, {63'd0, KE_EXP});

    // 5: reset with skid full, then a clean packet
    @(posedge sclk); #1 rx_rdy = 0;
    data_type = 2'd2; exp_beats = 16'd4; rx_en = 1;
    send_beat(64'hA1, 8'hFF, 1'b0, 4'b0100);
    check("keep_err_cleared", {63'd0, keep_err}, 64'd0);
    send_beat(64'hA2, 8'hFF, 1'b0, 4'b0100);
    s_axis_tvalid = 0;
    #2 s_rst_n = 0;
    #1;
    check("mid_rst_rx_vld", {60'd0, rx_vld}, 64'd0);
    check("mid_rst_rx_data", rx_data, 64'd0);
    check("mid_rst_rx_last", {63'd0, rx_last}, 64'd0);
    check("mid_rst_tready", {63'd0, s_axis_tready}, 64'd0);
    check("mid_rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
    sb.delete();
    rx_en = 0; rx_rdy = 1;
    @(posedge sclk); #1 s_rst_n = 1;
    repeat (2) @(posedge sclk);
    #1;
    run_pkt(0, 3, 3, 64'h5000000, -1, -1);
    wait_done(1'b0, 3);

    repeat (3) @(posedge sclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
